// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate divider, column/row counters, sync and
// blanking flags, and line/frame start pulses for the VGA display pipeline.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  output logic [31:0] col,
  output logic [31:0] row,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        vnotactive,
  output logic        pix_tick,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]  div_q, div_d;
  logic [31:0] col_q, col_d;
  logic [31:0] row_q, row_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic        vnotactive_q, vnotactive_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Pixel strobe; held low while in reset so no tick is seen during RST.
  assign pix_tick = en & ~RST & (div_q == DIV_LAST);

  // Next divider and counter values; everything holds while en is low.
  always_comb begin
    div_d = div_q;
    col_d = col_q;
    row_d = row_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end
    if (pix_tick) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? 32'd0 : row_q + 32'd1;
      end else begin
        col_d = col_q + 32'd1;
      end
    end
  end

  // Flags derived from the next coordinates so they switch on the same edge.
  always_comb begin
    hsync_d       = ((col_d >= HS_START) && (col_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((row_d >= VS_START) && (row_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (col_d < H_ACT) && (row_d < V_ACT);
    vnotactive_d  = (row_d >= V_ACT);
    line_start_d  = pix_tick && (col_d == 32'd0);
    frame_start_d = line_start_d && (row_d == 32'd0);
  end

  // State register with asynchronous reset to the start of a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      vnotactive_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      vnotactive_q  <= vnotactive_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Output mapping.
  always_comb begin
    col         = col_q;
    row         = row_q;
    hsync       = hsync_q;
    vsync       = vsync_q;
    video_on    = video_on_q;
    vnotactive  = vnotactive_q;
    line_start  = line_start_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (CLK_DIV=2, active-low
// sync) and a shrunken raster instance (CLK_DIV=1, active-high sync) checked
// every cycle against an arithmetic model based on enabled-edge counts.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b;

  always #5 clk = ~clk;

  logic [31:0] col_a, row_a, col_b, row_b;
  logic hs_a, vs_a, vo_a, vn_a, pt_a, ls_a, fs_a;
  logic hs_b, vs_b, vo_b, vn_b, pt_b, ls_b, fs_b;

  vga_timing_gen u_def (
    .CLK(clk), .RST(rst), .en(en_a), .col(col_a), .row(row_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vo_a), .vnotactive(vn_a), .pix_tick(pt_a), .line_start(ls_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b1)
  ) u_small (
    .CLK(clk), .RST(rst), .en(en_b), .col(col_b), .row(row_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vo_b), .vnotactive(vn_b), .pix_tick(pt_b), .line_start(ls_b),
    .frame_start(fs_b)
  );

  // Per-instance timing: index 0 = u_def, 1 = u_small.
  int unsigned p_div [2] = '{2, 1};
  int unsigned p_ha  [2] = '{640, 40};
  int unsigned p_hfp [2] = '{16, 4};
  int unsigned p_hs  [2] = '{96, 6};
  int unsigned p_ht  [2] = '{800, 55};
  int unsigned p_va  [2] = '{480, 20};
  int unsigned p_vfp [2] = '{10, 3};
  int unsigned p_vs  [2] = '{2, 2};
  int unsigned p_vt  [2] = '{525, 29};
  bit          p_pol [2] = '{1'b0, 1'b1};

  // Model state: enabled edges since reset, and expected pulse levels.
  int unsigned e [2];
  bit m_ls [2];
  bit m_fs [2];

  int n_cmp = 0;
  int n_bad = 0;
  int frames_b;

  function automatic int unsigned m_col(int k);
    return (e[k] / p_div[k]) % p_ht[k];
  endfunction

  function automatic int unsigned m_row(int k);
    return ((e[k] / p_div[k]) / p_ht[k]) % p_vt[k];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(int k, bit en_k);
    bit tick;
    if (rst) begin
      e[k] = 0; m_ls[k] = 1'b0; m_fs[k] = 1'b0;
    end else begin
      tick = en_k && ((e[k] % p_div[k]) == p_div[k] - 1);
      if (en_k) e[k]++;
      m_ls[k] = tick && (m_col(k) == 0);
      m_fs[k] = m_ls[k] && (m_row(k) == 0);
    end
  endtask

  task automatic check_dut(int k, bit en_k, logic [31:0] c, logic [31:0] r, logic [6:0] fl);
    int unsigned mc, mr;
    bit hs, vs, vo, vn, pt;
    string nm;
    mc = m_col(k);
    mr = m_row(k);
    hs = (mc >= p_ha[k] + p_hfp[k] && mc < p_ha[k] + p_hfp[k] + p_hs[k]) ? p_pol[k] : !p_pol[k];
    vs = (mr >= p_va[k] + p_vfp[k] && mr < p_va[k] + p_vfp[k] + p_vs[k]) ? p_pol[k] : !p_pol[k];
    vo = (mc < p_ha[k]) && (mr < p_va[k]);
    vn = (mr >= p_va[k]);
    pt = !rst && en_k && ((e[k] % p_div[k]) == p_div[k] - 1);
    nm = (k == 0) ? "def" : "small";
    chk({nm, ".col"}, 64'(c), 64'(mc));
    chk({nm, ".row"}, 64'(r), 64'(mr));
    chk({nm, ".flags{hs,vs,vo,vn,pt,ls,fs}"}, 64'(fl),
        64'({hs, vs, vo, vn, pt, m_ls[k], m_fs[k]}));
  endtask

  task automatic check_all();
    check_dut(0, en_a, col_a, row_a, {hs_a, vs_a, vo_a, vn_a, pt_a, ls_a, fs_a});
    check_dut(1, en_b, col_b, row_b, {hs_b, vs_b, vo_b, vn_b, pt_b, ls_b, fs_b});
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge(0, en_a);
    model_edge(1, en_b);
    @(negedge clk);
    check_all();
    if (fs_b) frames_b++;
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
    e = '{0, 0}; m_ls = '{0, 0}; m_fs = '{0, 0};
    frames_b = 0;
    @(negedge clk);
    check_all();
    repeat (3) step();

    // Release; first advance lands on the CLK_DIV-th edge.
    rst = 1'b0;
    step();
    chk("def.col_after_edge1", 64'(col_a), 64'd0);
    step();
    chk("def.col_after_edge2", 64'(col_a), 64'd1);

    // Run the default raster to col 300, then hold en low for 37 clocks.
    for (int i = 0; i < 2000 && m_col(0) != 300; i++) step();
    chk("def.reach_col300", 64'(col_a), 64'd300);
    en_a = 1'b0;
    repeat (37) step();
    chk("def.hold_col300", 64'(col_a), 64'd300);
    en_a = 1'b1;

    // Across the line wrap and into the next lines, small unit sees random en.
    for (int i = 0; i < 3400; i++) begin
      en_b = ($urandom_range(3) != 0);
      step();
    end
    chk("def.row_after_lines", 64'(row_a), 64'(m_row(0)));

    // Random enable on both instances.
    for (int i = 0; i < 3000; i++) begin
      en_a = ($urandom_range(4) != 0);
      en_b = ($urandom_range(4) != 0);
      step();
    end

    // Asynchronous reset mid-frame: outputs must drop before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    e = '{0, 0}; m_ls = '{0, 0}; m_fs = '{0, 0};
    check_all();
    @(negedge clk);
    step();
    rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
    frames_b = 0;

    // Two full frames of the small raster at one pixel per clock.
    repeat (1595 * 2 + 100) step();
    chk("small.frame_starts", 64'(frames_b), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing source for the tic-tac-toe display pipeline. Generates the pixel coordinates (col, row), the sync pulses and the blanking flags consumed by the board-drawing block and the VGA connector. A programmable divider derives the pixel rate from the system clock. Default timing is 640x480 at 60 Hz.

Parameters:
CLK_DIV, 2, system clocks per pixel; legal range 1..16; 1 means every CLK is a pixel tick
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BP, 33, vertical back porch, in lines
SYNC_POL, 0, asserted level of hsync/vsync; 0 = active-low

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
en  input  1  run enable; when low, divider and counters hold their values
col  output  32  horizontal pixel count, 0..H_TOTAL-1, zero-extended
row  output  32  vertical line count, 0..V_TOTAL-1, zero-extended
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
video_on  output  1  high when col < H_ACTIVE and row < V_ACTIVE
vnotactive  output  1  high when row >= V_ACTIVE (vertical blanking); safe window for board updates
pix_tick  output  1  one-CLK strobe; counters advance on the edge where it is high
line_start  output  1  one-CLK pulse, coincident with the edge on which col becomes 0
frame_start  output  1  one-CLK pulse, coincident with the edge on which col and row both become 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (RST high, asynchronous):
  - divider = 0, col = 0, row = 0.
  - hsync = vsync = !SYNC_POL (deasserted).
  - video_on = 1, vnotactive = 0.
  - pix_tick = line_start = frame_start = 0.
- Divider:
  - Counts 0..CLK_DIV-1 while en = 1.
  - pix_tick is high when divider == CLK_DIV-1 and en = 1. For CLK_DIV = 1, pix_tick = en.
- Counters advance on a CLK edge where pix_tick = 1:
  - col increments. At H_TOTAL-1, col wraps to 0 and row increments.
  - At row = V_TOTAL-1 with col wrapping, row also wraps to 0.
  - No other wrap points; col never equals H_TOTAL and row never equals V_TOTAL.
- Registered flags:
  - hsync, vsync, video_on and vnotactive are registered and computed from the next counter values, so they change on the same edge as col/row. Zero-cycle skew to the coordinates.
  - hsync asserted (= SYNC_POL) iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. vsync is level-based per line, not per pixel.
- Pulses:
  - line_start and frame_start are registered one-CLK pulses, high in the cycle after the advancing edge.
  - Both are high only when that advance produced col = 0 (line_start), or col = 0 and row = 0 (frame_start).
  - No pulse is emitted at reset release.
- en:
  - When en = 0, divider and counters freeze, pix_tick = 0 and the level outputs hold.
  - line_start and frame_start return to 0 after their single cycle.
  - Resuming continues from the held divider value; no state is lost.
- Reset mid-frame: all state returns immediately (asynchronously) to the reset values. The next frame starts from (0,0) with full timing.
- First advance after reset release with en = 1: on the CLK_DIV-th rising edge.

Test Plan:
- Reset/start: CLK_DIV=2, en=1, release RST.
  -> col=0 for 2 edges, col=1 after 2nd edge.
  -> hsync=vsync=1, video_on=1, vnotactive=0, no frame_start pulse at release.
- Line timing: run 1 line.
  -> hsync low exactly for col 656..751 (96 ticks = 192 CLKs).
  -> video_on low from col 640.
  -> col wraps 799 -> 0 with row 0 -> 1 and one line_start pulse.
- Frame timing: run 840000 CLKs.
  -> vsync low only on rows 490..491.
  -> vnotactive high for rows 480..524.
  -> exactly one frame_start, at the wrap (799,524) -> (0,0).
- en hold: drop en for 37 CLKs at col=300.
  -> col, divider and outputs frozen, pix_tick=0.
  -> after en returns, col=301 after the remaining divider cycles.
- Mid-frame reset: assert RST at row=200, col=400 for 1 CLK.
  -> outputs immediately at reset values.
  -> next frame_start after exactly 840000 CLKs from release.
- CLK_DIV=1 build: pix_tick = en every cycle; one frame = 420000 CLKs; hsync width = 96 CLKs.
